// File: rtl/usb_crc_engine_if.sv
// usb_crc_engine_if: serial CRC engine control and result bundle.
// Master drives the bit stream and commands; slave is the engine.
interface usb_crc_engine_if #(
   parameter int CRC_WIDTH = 5
);
   logic                 crc_clear;
   logic                 shift_enable;
   logic                 crc_enable;
   logic                 d_orig;
   logic                 emit_start;
   logic                 crc_out;
   logic                 crc_out_valid;
   logic                 emit_done;
   logic                 crc_match;
   logic [CRC_WIDTH-1:0] crc_value;
   logic                 busy;

   modport master (
      output crc_clear, shift_enable, crc_enable, d_orig, emit_start,
      input  crc_out, crc_out_valid, emit_done, crc_match, crc_value, busy
   );

   modport slave (
      input  crc_clear, shift_enable, crc_enable, d_orig, emit_start,
      output crc_out, crc_out_valid, emit_done, crc_match, crc_value, busy
   );
endinterface

// File: rtl/usb_crc_engine.sv
// usb_crc_engine: bit-serial USB CRC accumulator and emitter.
// Accumulates unstuffed data bits, then shifts out the complemented CRC.
module usb_crc_engine #(
   parameter int                   CRC_WIDTH = 5,
   parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(5'b00101),
   parameter logic [CRC_WIDTH-1:0] INIT      = '1,
   parameter logic [CRC_WIDTH-1:0] RESIDUE   = CRC_WIDTH'(5'b01100)
) (
   input logic               clk,
   input logic               n_rst,
   usb_crc_engine_if.slave   bus
);
   localparam int CW = $clog2(CRC_WIDTH + 1);
   localparam int MSB = CRC_WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(CRC_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CRC_WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 fb;

   // State register, CRC register, emit counter and done pulse.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         q_q     <= INIT;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next state: clear beats emit_start, which beats accumulation.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      fb      = bus.d_orig ^ q_q[MSB];
      if (bus.crc_clear) begin
         state_d = IDLE;
         q_d     = INIT;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE, ACCUM: begin
               if (bus.emit_start) begin
                  state_d = EMIT;
                  cnt_d   = '0;
               end else if (bus.shift_enable && bus.crc_enable) begin
                  q_d     = {q_q[MSB-1:0], 1'b0} ^ (fb ? POLY : '0);
                  state_d = ACCUM;
               end
            end
            EMIT: begin
               if (bus.shift_enable) begin
                  if (cnt_q == LAST) begin
                     state_d = IDLE;
                     q_d     = INIT;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     q_d   = {q_q[MSB-1:0], 1'b1};
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs: emitted bit is the complemented MSB, only while emitting.
   always_comb begin
      bus.busy          = (state_q == EMIT);
      bus.crc_out       = (state_q == EMIT) ? ~q_q[MSB] : 1'b0;
      bus.crc_out_valid = (state_q == EMIT) && bus.shift_enable;
      bus.emit_done     = done_q;
      bus.crc_match     = (q_q == RESIDUE) && (state_q != EMIT);
      bus.crc_value     = q_q;
   end
endmodule

// File: tb/tb_usb_crc_engine.sv
// tb_usb_crc_engine: directed checks of CRC5 and CRC16 engines.
// Expected values are hand-derived constants.
module tb_usb_crc_engine;
   logic clk;
   logic n_rst;
   int   n_chk;
   int   n_fail;
   int   done5;
   logic [15:0] cap;
   logic [15:0] pay;

   usb_crc_engine_if #(.CRC_WIDTH(5))  if5 ();
   usb_crc_engine_if #(.CRC_WIDTH(16)) if16 ();

   usb_crc_engine u5 (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (if5.slave)
   );

   usb_crc_engine #(
      .CRC_WIDTH (16),
      .POLY      (16'h8005),
      .INIT      (16'hFFFF),
      .RESIDUE   (16'h800D)
   ) u16 (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (if16.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (if5.emit_done) done5++;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic acc5(input logic d);
      if5.shift_enable = 1'b1;
      if5.crc_enable   = 1'b1;
      if5.d_orig       = d;
      tick();
      if5.shift_enable = 1'b0;
      if5.crc_enable   = 1'b0;
      if5.d_orig       = 1'b0;
   endtask

   task automatic acc16(input logic d);
      if16.shift_enable = 1'b1;
      if16.crc_enable   = 1'b1;
      if16.d_orig       = d;
      tick();
      if16.shift_enable = 1'b0;
      if16.crc_enable   = 1'b0;
   endtask

   task automatic start5();
      if5.emit_start = 1'b1;
      tick();
      if5.emit_start = 1'b0;
   endtask

   initial begin
      logic [4:0] exp_bits;
      n_chk = 0;
      n_fail = 0;
      done5 = 0;
      n_rst = 1'b0;
      {if5.crc_clear, if5.shift_enable, if5.crc_enable} = '0;
      {if5.d_orig, if5.emit_start} = '0;
      {if16.crc_clear, if16.shift_enable, if16.crc_enable} = '0;
      {if16.d_orig, if16.emit_start} = '0;
      tick();
      check("rst_value", if5.crc_value, 5'b11111);
      check("rst_busy", if5.busy, 1'b0);
      check("rst_valid", if5.crc_out_valid, 1'b0);
      check("rst_done", if5.emit_done, 1'b0);
      check("rst_out", if5.crc_out, 1'b0);
      check("rst_match", if5.crc_match, 1'b0);
      n_rst = 1'b1;
      tick();

      // 11 zero bits
      for (int i = 0; i < 11; i++) acc5(1'b0);
      check("z11_value", if5.crc_value, 5'b10111);
      check("z11_match", if5.crc_match, 1'b0);
      tick();
      check("hold_value", if5.crc_value, 5'b10111);

      // emit the CRC: 0,1,0,0,0
      start5();
      check("emit_busy", if5.busy, 1'b1);
      check("emit_hold", if5.crc_value, 5'b10111);
      check("emit_nostb_valid", if5.crc_out_valid, 1'b0);
      exp_bits = 5'b00010;
      for (int i = 0; i < 5; i++) begin
         if5.shift_enable = 1'b1;
         if5.crc_enable   = 1'b1;
         if5.d_orig       = 1'b1;
         #1;
         check($sformatf("emit_bit%0d", i), if5.crc_out, exp_bits[i]);
         check($sformatf("emit_vld%0d", i), if5.crc_out_valid, 1'b1);
         tick();
      end
      if5.shift_enable = 1'b0;
      if5.crc_enable   = 1'b0;
      if5.d_orig       = 1'b0;
      check("emit_done_pulse", if5.emit_done, 1'b1);
      check("emit_end_value", if5.crc_value, 5'b11111);
      check("emit_end_busy", if5.busy, 1'b0);
      tick();
      check("emit_done_low", if5.emit_done, 1'b0);
      check("emit_done_cnt", done5, 1);

      // residue after data plus its CRC
      for (int i = 0; i < 11; i++) acc5(1'b0);
      acc5(1'b0); acc5(1'b1); acc5(1'b0); acc5(1'b0); acc5(1'b0);
      check("res_value", if5.crc_value, 5'b01100);
      check("res_match", if5.crc_match, 1'b1);

      // clear after the second emitted bit
      if5.crc_clear = 1'b1;
      tick();
      if5.crc_clear = 1'b0;
      for (int i = 0; i < 11; i++) acc5(1'b0);
      start5();
      if5.shift_enable = 1'b1;
      tick();
      tick();
      if5.emit_start = 1'b1;
      if5.crc_clear  = 1'b1;
      tick();
      if5.crc_clear  = 1'b0;
      if5.emit_start = 1'b0;
      if5.shift_enable = 1'b0;
      check("clr_busy", if5.busy, 1'b0);
      check("clr_value", if5.crc_value, 5'b11111);
      check("clr_done", if5.emit_done, 1'b0);
      tick();
      tick();
      check("clr_done_cnt", done5, 1);

      // emit_start wins over a simultaneous data bit
      if5.emit_start = 1'b1;
      acc5(1'b1);
      if5.emit_start = 1'b0;
      check("prio_value", if5.crc_value, 5'b11111);
      check("prio_busy", if5.busy, 1'b1);
      if5.crc_clear = 1'b1;
      tick();
      if5.crc_clear = 1'b0;

      // async reset mid-accumulation
      acc5(1'b0); acc5(1'b0); acc5(1'b0);
      check("pre_rst_value", if5.crc_value, 5'b00011);
      #2;
      n_rst = 1'b0;
      #1;
      check("arst_value", if5.crc_value, 5'b11111);
      check("arst_busy", if5.busy, 1'b0);
      check("arst_valid", if5.crc_out_valid, 1'b0);
      tick();
      n_rst = 1'b1;
      tick();
      acc5(1'b0);
      check("post_rst_value", if5.crc_value, 5'b11011);

      // CRC16 round trip
      pay = 16'hA53C;
      for (int i = 0; i < 16; i++) acc16(pay[i]);
      if16.emit_start = 1'b1;
      tick();
      if16.emit_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if16.shift_enable = 1'b1;
         #1;
         cap[i] = if16.crc_out;
         check($sformatf("c16_vld%0d", i), if16.crc_out_valid, 1'b1);
         tick();
      end
      if16.shift_enable = 1'b0;
      check("c16_done", if16.emit_done, 1'b1);
      check("c16_init", if16.crc_value, 16'hFFFF);
      for (int i = 0; i < 16; i++) acc16(pay[i]);
      for (int i = 0; i < 16; i++) acc16(cap[i]);
      check("c16_value", if16.crc_value, 16'h800D);
      check("c16_match", if16.crc_match, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
